// File: rtl/pulse_counter_pkg.sv
// Shared constants for the pulse counter: BCD width, default sizing and the
// active-low 7-segment decode used by the display scan.
package pulse_counter_pkg;

    localparam int unsigned BCD_W            = 4;
    localparam int unsigned SEG_W            = 7;
    localparam int unsigned DIGITS_DEFAULT   = 4;
    localparam int unsigned SCAN_DIV_DEFAULT = 50000;

    // Segment order {g,f,e,d,c,b,a}, 0 = lit
    localparam logic [SEG_W-1:0] SEG_0   = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] s;
        unique case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: increments on cin, wraps 9 -> 0 and propagates carry
// combinationally so all decades update on the same edge.
module bcd_digit
    import pulse_counter_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic             clr,
    input  logic             cin,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    logic [BCD_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (cin) begin
            q_d = bcd_inc(q_q);
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign cout = cin & (q_q == 4'd9);

endmodule

// File: rtl/pulse_bcd_counter.sv
// BCD pulse counter: rising-edge detect on CLK_cont, DIGITS-decade count with sticky
// overflow, holdable output latch and a multiplexed active-low 7-segment scan.
module pulse_bcd_counter
    import pulse_counter_pkg::*;
#(
    parameter int unsigned DIGITS   = DIGITS_DEFAULT,
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    CLK_cont,
    input  logic                    Clear,
    input  logic                    Hold,
    output logic [BCD_W*DIGITS-1:0] Count_BCD,
    output logic                    Overflow,
    output logic [SEG_W-1:0]        Seg,
    output logic [DIGITS-1:0]       An
);

    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PrescW = $clog2(SCAN_DIV);

    logic                    cont_q;
    logic                    inc;
    logic [DIGITS:0]         carry;
    logic [BCD_W*DIGITS-1:0] cnt, cnt_next;
    logic [BCD_W*DIGITS-1:0] disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [PrescW-1:0]       presc_q, presc_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [DIGITS-1:0]       an_q, an_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic [BCD_W-1:0]        digit_sel;

    assign inc      = CLK_cont & ~cont_q;
    assign carry[0] = inc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .CLK   (CLK),
            .Reset (Reset),
            .clr   (Clear),
            .cin   (carry[g]),
            .q     (cnt[g*BCD_W +: BCD_W]),
            .cout  (carry[g+1])
        );
    end

    // Value the decades will hold after this edge; feeds the output latch with no lag.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (Clear) begin
                cnt_next[i*BCD_W +: BCD_W] = '0;
            end else if (carry[i]) begin
                cnt_next[i*BCD_W +: BCD_W] = bcd_inc(cnt[i*BCD_W +: BCD_W]);
            end else begin
                cnt_next[i*BCD_W +: BCD_W] = cnt[i*BCD_W +: BCD_W];
            end
        end
    end

    always_comb begin
        disp_d    = Hold ? disp_q : cnt_next;
        ovf_d     = Clear ? 1'b0 : (ovf_q | carry[DIGITS]);
        presc_d   = presc_q + 1'b1;
        idx_d     = idx_q;
        if (presc_q == PrescW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        digit_sel = '0;
        an_d      = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IdxW'(i)) begin
                digit_sel = disp_q[i*BCD_W +: BCD_W];
                an_d[i]   = 1'b0;
            end
        end
        seg_d     = bcd_to_seg(digit_sel);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cont_q  <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= SEG_0;
        end else begin
            cont_q  <= CLK_cont;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign Count_BCD = disp_q;
    assign Overflow  = ovf_q;
    assign Seg       = seg_q;
    assign An        = an_q;

endmodule

// File: tb/tb_pulse_bcd_counter.sv
// Scoreboard bench for pulse_bcd_counter: an integer reference model queues the expected
// post-edge outputs and a monitor compares them just after every rising edge.
module tb_pulse_bcd_counter;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic        CLK = 1'b0;
    logic        Reset, CLK_cont, Clear, Hold;
    logic [15:0] Count_BCD;
    logic        Overflow;
    logic [6:0]  Seg;
    logic [3:0]  An;

    always #5 CLK = ~CLK;

    pulse_bcd_counter #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .CLK_cont  (CLK_cont),
        .Clear     (Clear),
        .Hold      (Hold),
        .Count_BCD (Count_BCD),
        .Overflow  (Overflow),
        .Seg       (Seg),
        .An        (An)
    );

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
        logic [6:0]  seg;
        logic [3:0]  an;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: plain integers
    int   m_cnt, m_disp, m_k;
    bit   m_ovf, m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic void model_reset();
        m_cnt  = 0;
        m_disp = 0;
        m_k    = 0;
        m_ovf  = 1'b0;
        m_prev = 1'b0;
    endfunction

    // Called at a negedge: apply inputs, queue expectation for the coming posedge.
    task automatic step(input bit c, input bit cl, input bit h);
        exp_t e;
        bit   inc;
        int   idx;
        CLK_cont = c;
        Clear    = cl;
        Hold     = h;
        inc      = c && !m_prev;
        m_prev   = c;
        if (cl) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (inc) begin
            if (m_cnt == 9999) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        m_k++;
        idx   = (m_k / SCAN_DIV) % DIGITS;
        e.seg = SEG_TAB[(m_disp / pow10(idx)) % 10];
        e.an  = 4'hf;
        e.an[idx] = 1'b0;
        if (!h) m_disp = m_cnt;
        e.bcd = to_bcd(m_disp);
        e.ovf = m_ovf;
        sb.push_back(e);
        @(negedge CLK);
    endtask

    task automatic pulse(input int hi, input int lo, input bit h);
        repeat (hi) step(1'b1, 1'b0, h);
        repeat (lo) step(1'b0, 1'b0, h);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 32'(Count_BCD), 32'h0);
        chk({tag, "_ovf"},   32'(Overflow),  32'h0);
        chk({tag, "_an"},    32'(An),        32'he);
        chk({tag, "_seg"},   32'(Seg),       32'h40);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("count_bcd", 32'(Count_BCD), 32'(e.bcd));
                chk("overflow",  32'(Overflow),  32'(e.ovf));
                chk("seg",       32'(Seg),       32'(e.seg));
                chk("an",        32'(An),        32'(e.an));
            end
        end
    end

    initial begin : driver
        int  n;
        bit  h;
        Reset    = 1'b0;
        CLK_cont = 1'b0;
        Clear    = 1'b0;
        Hold     = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        Reset = 1'b1;
        #1;
        check_reset_state("reset");

        // Pulses of differing widths -> 5
        pulse(1, 2, 1'b0);
        pulse(2, 2, 1'b0);
        pulse(3, 2, 1'b0);
        pulse(8, 2, 1'b0);
        pulse(35, 2, 1'b0);

        // Wrap past 9999 -> 0000 with overflow, then clear
        step(1'b0, 1'b1, 1'b0);
        repeat (10000) pulse(1, 1, 1'b0);
        pulse(0, 2, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        pulse(0, 2, 1'b0);

        // Clear coincident with a rise held for 5 cycles
        pulse(1, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        pulse(4, 3, 1'b0);

        // Hold freezes the output while counting continues
        repeat (12) pulse(1, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (3) pulse(2, 2, 1'b1);
        pulse(0, 8, 1'b0);
        // Clear under hold zeroes the count only
        pulse(2, 1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        pulse(0, 3, 1'b1);
        pulse(0, 2, 1'b0);

        // Randomized traffic
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) h = ~h;
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), h);
        end

        // Async reset mid-pulse at 0037 and mid-scan at index 2
        step(1'b0, 1'b1, 1'b0);
        repeat (36) pulse(1, 1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        n = 0;
        while (((m_k / SCAN_DIV) % DIGITS) != 2 && n < 20) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("scan_reaches_idx2", 32'(n < 20), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        pulse(3, 3, 1'b0);

        // Drain scoreboard with a bounded wait
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(posedge CLK);
            n++;
        end
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
